maxnet_controller: RTL and testbench

//  Control FSM for the Maxnet network. It sequences the N processing units (PUs):
//   - loads the initial activation vector;
//   - pulses the PU result-register loads;
//   - feeds PU results back as the next activations;
//   - counts surviving (non-zero) neurons and stops when at most one survives.

---
 rtl/maxnet_controller.sv | 132 +++++++++++++
 tb/tb_maxnet_controller.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/maxnet_controller.sv
// Maxnet sequencing FSM: loads activations, strobes the PU result registers,
// feeds results back and stops once at most one neuron survives or the
// iteration limit is reached. Drives only mux selects and load enables.
//
// Handshake: start is a request sampled only in IDLE (ignored while busy);
// completion is a one-cycle done pulse, with timeout/winner/winner_valid/
// iter_count valid in that cycle. winner, winner_valid and iter_count hold
// until the next accepted start.
module maxnet_controller #(
  parameter int N        = 4,
  parameter int MAX_ITER = 64,
  parameter int ITER_W   = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [N-1:0]      nz,
  output logic              sel_init,
  output logic              ld_a,
  output logic              result_signal,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [N-1:0]      winner,
  output logic              winner_valid,
  output logic [ITER_W-1:0] iter_count,
  output logic [2:0]        dbg_state
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_COMPUTE = 3'd2;
  localparam logic [2:0] S_CHECK   = 3'd3;
  localparam logic [2:0] S_UPDATE  = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  localparam int POP_W = $clog2(N + 1);
  localparam logic [POP_W-1:0]  POP_ONE   = POP_W'(1);
  localparam logic [ITER_W-1:0] ITER_MAX  = ITER_W'(MAX_ITER);
  localparam logic [ITER_W-1:0] ITER_STEP = ITER_W'(1);

  logic [2:0]        state_q, state_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic [N-1:0]      winner_q, winner_d;
  logic              winner_valid_q, winner_valid_d;
  logic              timeout_q, timeout_d;
  logic [POP_W-1:0]  pop;
  logic [ITER_W-1:0] iter_inc;

  // Count surviving neurons reported by the PU array.
  always_comb begin
    pop = '0;
    for (int i = 0; i < N; i++) begin
      pop = pop + POP_W'(nz[i]);
    end
  end

  // Iteration counter saturates at the limit so it can never wrap.
  assign iter_inc = (iter_q == ITER_MAX) ? iter_q : iter_q + ITER_STEP;

  // Next-state and result-register logic.
  always_comb begin
    state_d        = state_q;
    iter_d         = iter_q;
    winner_d       = winner_q;
    winner_valid_d = winner_valid_q;
    timeout_d      = timeout_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d        = S_LOAD;
          iter_d         = '0;
          winner_d       = '0;
          winner_valid_d = 1'b0;
          timeout_d      = 1'b0;
        end
      end
      S_LOAD:    state_d = S_COMPUTE;
      S_COMPUTE: state_d = S_CHECK;
      S_CHECK: begin
        iter_d = iter_inc;
        // Convergence is tested first so it wins over the limit.
        if (pop <= POP_ONE) begin
          state_d        = S_DONE;
          winner_d       = nz;
          winner_valid_d = (pop == POP_ONE);
          timeout_d      = 1'b0;
        end else if (iter_inc == ITER_MAX) begin
          state_d        = S_DONE;
          winner_d       = '0;
          winner_valid_d = 1'b0;
          timeout_d      = 1'b1;
        end else begin
          state_d = S_UPDATE;
        end
      end
      S_UPDATE:  state_d = S_COMPUTE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // State and result registers; reset aborts any run without a done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      iter_q         <= '0;
      winner_q       <= '0;
      winner_valid_q <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      iter_q         <= iter_d;
      winner_q       <= winner_d;
      winner_valid_q <= winner_valid_d;
      timeout_q      <= timeout_d;
    end
  end

  // Moore strobes decoded from the current state.
  assign sel_init      = (state_q == S_LOAD);
  assign ld_a          = (state_q == S_LOAD) || (state_q == S_UPDATE);
  assign result_signal = (state_q == S_COMPUTE);
  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);
  assign timeout       = timeout_q;
  assign winner        = winner_q;
  assign winner_valid  = winner_valid_q;
  assign iter_count    = iter_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_maxnet_controller.sv
// Bench for maxnet_controller with a small iteration limit so timeouts are
// reachable. Each run is described by the nz vector presented at every CHECK;
// the reference model derives the expected outcome and done cycle from the
// convergence rules, and per-cycle strobes from the fixed 3-cycle cadence.
module tb_maxnet_controller;

  localparam int N        = 4;
  localparam int MAX_ITER = 3;
  localparam int ITER_W   = 7;

  logic              clk;
  logic              rst;
  logic              start;
  logic [N-1:0]      nz;
  logic              sel_init;
  logic              ld_a;
  logic              result_signal;
  logic              busy;
  logic              done;
  logic              timeout;
  logic [N-1:0]      winner;
  logic              winner_valid;
  logic [ITER_W-1:0] iter_count;
  logic [2:0]        dbg_state;

  int vectors     = 0;
  int miscompares = 0;

  logic [N-1:0] plan [0:MAX_ITER-1];
  logic [N-1:0] exp_q[$];
  int           exp_k;
  logic         exp_val;
  logic         exp_to;

  maxnet_controller #(.N(N), .MAX_ITER(MAX_ITER), .ITER_W(ITER_W)) dut (
    .clk(clk), .rst(rst), .start(start), .nz(nz),
    .sel_init(sel_init), .ld_a(ld_a), .result_signal(result_signal),
    .busy(busy), .done(done), .timeout(timeout), .winner(winner),
    .winner_valid(winner_valid), .iter_count(iter_count),
    .dbg_state(dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference model: walk the CHECK vectors in order and apply the stop rules.
  task automatic model();
    logic [N-1:0] w;
    int p;
    exp_k = 0; w = '0; exp_val = 1'b0; exp_to = 1'b0;
    for (int k = 1; k <= MAX_ITER; k++) begin
      if (exp_k == 0) begin
        p = $countones(plan[k-1]);
        if (p <= 1) begin
          exp_k = k; w = plan[k-1]; exp_val = (p == 1); exp_to = 1'b0;
        end else if (k == MAX_ITER) begin
          exp_k = k; w = '0; exp_val = 1'b0; exp_to = 1'b1;
        end
      end
    end
    exp_q.push_back(w);
  endtask

  // Driver: entered in an IDLE cycle just after a falling edge.
  task automatic run(input bit pulse_busy, input bit hold_start);
    int done_c;
    logic [N-1:0] w;
    model();
    done_c = 1 + 3 * exp_k;
    w = exp_q.pop_front();
    start = 1'b1;
    for (int c = 1; c <= done_c; c++) begin
      @(negedge clk);
      start = (pulse_busy && (c == 2 || c == 3)) || (hold_start && c == done_c);
      nz = (c % 3 == 0) ? plan[c/3-1] : 4'($urandom_range(0, 15));
      chk("busy", 32'(busy), 32'd1);
      chk("done", 32'(done), 32'(c == done_c));
      chk("sel_init", 32'(sel_init), 32'(c == 1));
      chk("ld_a", 32'(ld_a), 32'(c == 1 || (c % 3 == 1 && c != done_c)));
      chk("result_signal", 32'(result_signal), 32'(c % 3 == 2));
      chk("strobe_excl", 32'(ld_a & result_signal), 32'd0);
      chk("iter_count", 32'(iter_count), 32'((c - 1) / 3));
      if (c == done_c) begin
        chk("winner", 32'(winner), 32'(w));
        chk("winner_valid", 32'(winner_valid), 32'(exp_val));
        chk("timeout", 32'(timeout), 32'(exp_to));
      end
    end
    @(negedge clk);
    start = hold_start;
    nz = 4'($urandom_range(0, 15));
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_done", 32'(done), 32'd0);
    chk("idle_ld_a", 32'(ld_a), 32'd0);
    chk("held_winner", 32'(winner), 32'(w));
    chk("held_valid", 32'(winner_valid), 32'(exp_val));
    chk("held_iter", 32'(iter_count), 32'(exp_k));
  endtask

  task automatic set_plan(input logic [N-1:0] a, input logic [N-1:0] b, input logic [N-1:0] c);
    plan[0] = a; plan[1] = b; plan[2] = c;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_ld_a"}, 32'(ld_a), 32'd0);
    chk({tag, "_sel"}, 32'(sel_init), 32'd0);
    chk({tag, "_res"}, 32'(result_signal), 32'd0);
    chk({tag, "_winner"}, 32'(winner), 32'd0);
    chk({tag, "_valid"}, 32'(winner_valid), 32'd0);
    chk({tag, "_timeout"}, 32'(timeout), 32'd0);
    chk({tag, "_iter"}, 32'(iter_count), 32'd0);
  endtask

  // Directed and random sequence
  initial begin
    rst = 1'b0; start = 1'b0; nz = '0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b1;
    @(negedge clk);

    // Single survivor on the first pass
    set_plan(4'b0100, 4'b0000, 4'b0000);
    run(1'b0, 1'b0);
    // Two feedback passes; convergence on the limit iteration wins
    set_plan(4'b1011, 4'b0011, 4'b0010);
    run(1'b0, 1'b0);
    // No survivors
    set_plan(4'b0000, 4'b1111, 4'b1111);
    run(1'b0, 1'b0);
    // Stuck pattern hits the iteration limit
    set_plan(4'b0011, 4'b0011, 4'b0011);
    run(1'b0, 1'b0);
    // start pulsed while busy must be ignored
    set_plan(4'b1100, 4'b1000, 4'b0000);
    run(1'b1, 1'b0);
    // start held through DONE chains straight into the next run
    set_plan(4'b0001, 4'b0000, 4'b0000);
    run(1'b0, 1'b1);
    set_plan(4'b0111, 4'b1110, 4'b1111);
    run(1'b0, 1'b0);

    // Reset asserted during UPDATE aborts the run with no done pulse
    set_plan(4'b1011, 4'b0011, 4'b0010);
    start = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      start = 1'b0;
      nz = (c % 3 == 0) ? plan[c/3-1] : 4'($urandom_range(0, 15));
    end
    chk("pre_reset_update_ld_a", 32'(ld_a), 32'd1);
    #2 rst = 1'b0;
    #1 chk_all_zero("async_reset");
    repeat (2) begin
      @(negedge clk);
      chk("reset_no_done", 32'(done), 32'd0);
    end
    rst = 1'b1;
    @(negedge clk);
    chk("post_reset_idle", 32'(busy), 32'd0);
    set_plan(4'b0010, 4'b0000, 4'b0000);
    run(1'b0, 1'b0);

    // Random runs
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < MAX_ITER; i++) begin
        plan[i] = ($urandom_range(0, 3) == 0) ? 4'(1 << $urandom_range(0, 3))
                                              : 4'($urandom_range(0, 15));
      end
      run(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) begin
        start = 1'b0;
        @(negedge clk);
      end
    end

    start = 1'b0;
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
